fetch_stage: RTL and testbench

- Instruction-fetch front end of the RV32I core, directly upstream of the combinational instruction memory.
- Owns the program counter and drives the word-aligned byte address into instruction memory.
- Captures the returned machine code into the IF/ID pipeline register for the decoder.
- Handles stall, flush, control-flow redirect and fetch-fault detection, with an explicit state machine.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the instruction memory
// address and fills the IF/ID register, with stall/flush/redirect and fault capture.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0004,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        fetch_fault_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Widened by one bit so the bound itself cannot overflow for large depths.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        pc_bad;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_bad   = ({1'b0, pc_q} >= PC_LIMIT) || (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_i && redirect_target_i[1:0] != 2'b00) begin
          state_d      = HALT;
          fault_d      = 1'b1;
          fault_addr_d = redirect_target_i;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (redirect_i) begin
          pc_d         = redirect_target_i;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (pc_bad) begin
          state_d      = HALT;
          fault_d      = 1'b1;
          fault_addr_d = pc_q;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (flush_i) begin
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
          if (!stall_i) pc_d = pc_plus4;
        end else if (!stall_i) begin
          ifid_d.pc    = pc_q;
          ifid_d.instr = imem_data_i;
          ifid_d.valid = 1'b1;
          pc_d         = pc_plus4;
          count_d      = count_q + 32'd1;
        end
      end
      HALT: ;  // absorbing until reset
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_q       <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign if_id_pc_o       = ifid_q.pc;
  assign if_id_pc_plus4_o = ifid_q.pc + 32'd4;
  assign if_id_instr_o    = ifid_q.instr;
  assign if_id_valid_o    = ifid_q.valid;
  assign fetch_fault_o    = fault_q;
  assign fault_addr_o     = fault_addr_q;
  assign fetch_count_o    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, flush, redirect, range fault,
// misaligned-redirect fault and asynchronous reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] imem_addr_o, imem_data_i;
  logic [31:0] if_id_pc_o, if_id_pc_plus4_o, if_id_instr_o;
  logic        if_id_valid_o, fetch_fault_o;
  logic [31:0] fault_addr_o, fetch_count_o;

  logic [31:0] mem [0:31];
  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Word1/word2 carry the boot encodings; every other word k is 0x1000+k.
  assign imem_data_i = (imem_addr_o < 32'd128) ? mem[imem_addr_o[6:2]] : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .if_id_pc_o(if_id_pc_o), .if_id_pc_plus4_o(if_id_pc_plus4_o),
    .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
    .fetch_fault_o(fetch_fault_o), .fault_addr_o(fault_addr_o),
    .fetch_count_o(fetch_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic [31:0] cnt, input logic [31:0] addr);
    chk({tag, ".pc"},    if_id_pc_o, pc);
    chk({tag, ".pc4"},   if_id_pc_plus4_o, pc + 32'd4);
    chk({tag, ".instr"}, if_id_instr_o, instr);
    chk({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, valid});
    chk({tag, ".count"}, fetch_count_o, cnt);
    chk({tag, ".addr"},  imem_addr_o, addr);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'h0000_1000 | k;
    mem[1] = 32'h1234_50b7;
    mem[2] = 32'h1234_5117;
    reset_n = 1'b0; stall_i = 0; flush_i = 0; redirect_i = 0; redirect_target_i = '0;

    tick(); tick();
    chk_ifid("rst", 32'd0, 32'h13, 1'b0, 32'd0, 32'd4);
    chk("rst.fault", {31'd0, fetch_fault_o}, 32'd0);
    chk("rst.faddr", fault_addr_o, 32'd0);

    reset_n = 1'b1;
    tick();  // BOOT edge: no capture
    chk_ifid("boot", 32'd0, 32'h13, 1'b0, 32'd0, 32'd4);
    tick();
    chk_ifid("f1", 32'd4, 32'h1234_50b7, 1'b1, 32'd1, 32'd8);
    tick();
    chk_ifid("f2", 32'd8, 32'h1234_5117, 1'b1, 32'd2, 32'd12);

    stall_i = 1;
    tick(); tick(); tick();
    chk_ifid("stall", 32'd8, 32'h1234_5117, 1'b1, 32'd2, 32'd12);
    stall_i = 0;
    tick();
    chk_ifid("resume", 32'd12, 32'h0000_1003, 1'b1, 32'd3, 32'd16);

    flush_i = 1; stall_i = 1;
    tick();
    chk_ifid("flstall", 32'd12, 32'h13, 1'b0, 32'd3, 32'd16);
    flush_i = 0; stall_i = 0;
    tick();
    chk_ifid("f4", 32'd16, 32'h0000_1004, 1'b1, 32'd4, 32'd20);

    flush_i = 1;
    tick();
    chk_ifid("flush", 32'd16, 32'h13, 1'b0, 32'd4, 32'd24);
    flush_i = 0;

    redirect_i = 1; redirect_target_i = 32'h1C; stall_i = 1;
    tick();
    chk_ifid("redir", 32'd16, 32'h13, 1'b0, 32'd4, 32'd28);
    redirect_i = 0; stall_i = 0;
    tick();
    chk_ifid("f7", 32'd28, 32'h0000_1007, 1'b1, 32'd5, 32'd32);

    for (int k = 0; k < 24; k++) tick();
    chk_ifid("f31", 32'd124, 32'h0000_101F, 1'b1, 32'd29, 32'd128);
    tick();
    chk_ifid("oob", 32'd124, 32'h13, 1'b0, 32'd29, 32'd128);
    chk("oob.fault", {31'd0, fetch_fault_o}, 32'd1);
    chk("oob.faddr", fault_addr_o, 32'd128);
    tick(); tick();
    chk_ifid("oobhold", 32'd124, 32'h13, 1'b0, 32'd29, 32'd128);

    reset_n = 1'b0;
    #2;  // asynchronous clear, no edge needed
    chk_ifid("arst", 32'd0, 32'h13, 1'b0, 32'd0, 32'd4);
    chk("arst.fault", {31'd0, fetch_fault_o}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();  // BOOT
    redirect_i = 1; redirect_target_i = 32'h22;
    tick();
    chk("mis.fault", {31'd0, fetch_fault_o}, 32'd1);
    chk("mis.faddr", fault_addr_o, 32'h22);
    chk_ifid("mis", 32'd0, 32'h13, 1'b0, 32'd0, 32'd4);
    redirect_target_i = 32'h10; flush_i = 1;
    tick(); tick();
    chk_ifid("halt", 32'd0, 32'h13, 1'b0, 32'd0, 32'd4);
    chk("halt.faddr", fault_addr_o, 32'h22);
    redirect_i = 0; flush_i = 0;

    reset_n = 1'b0;
    #2;
    chk("clr.fault", {31'd0, fetch_fault_o}, 32'd0);
    chk("clr.faddr", fault_addr_o, 32'd0);
    chk("clr.addr", imem_addr_o, 32'd4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
